// File: rtl/updown_ctrl.sv
`timescale 1ns/1ps
// updown_db: one button lane. It has a 2-FF synchronizer, a stable-level
// debounce counter, and a registered pulse on each accepted 0->1 transition.
module updown_db #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter runs only while the synced input disagrees with the accepted
  // level. The DB_CYCLES-th disagreeing cycle flips the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounce state and press pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
endmodule

// updown_ctrl: run/direction/rate controller that owns the 8-bit count.
module updown_ctrl #(
  parameter int         DB_CYCLES = 1_000_000,
  parameter logic [1:0] SEL_RESET = 2'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_dir,
  input  logic       btn_rate,
  input  logic       mode_bounce,
  input  logic       tick_in,
  output logic [1:0] sel,
  output logic [7:0] q,
  output logic       cnt_up,
  output logic       cnt_en,
  output logic       running
);
  localparam int NUM_BTN = 3;
  localparam int B_RUN   = 0;
  localparam int B_DIR   = 1;
  localparam int B_RATE  = 2;

  typedef enum logic {ST_STOP, ST_RUN} state_e;

  logic [NUM_BTN-1:0] btn_raw, press;
  assign btn_raw = {btn_rate, btn_dir, btn_run};

  // One debounce lane per button.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    updown_db #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_raw[i]),
      .press(press[i])
    );
  end

  logic tsync1_q, tsync2_q, tprev_q, tick;
  assign tick = tsync2_q & ~tprev_q;

  // tick_in synchronizer and rising-edge history. Falling edges are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tsync1_q <= 1'b0;
      tsync2_q <= 1'b0;
      tprev_q  <= 1'b0;
    end else begin
      tsync1_q <= tick_in;
      tsync2_q <= tsync1_q;
      tprev_q  <= tsync2_q;
    end
  end

  state_e     state_q, state_d;
  logic [7:0] q_q, q_d, q_nx;
  logic       cnt_up_q, cnt_up_d;
  logic       cnt_en_q, cnt_en_d;
  logic [1:0] sel_q, sel_d;
  logic       step, flip;

  // Next-count and limit handling. The step always uses the pre-update direction.
  // A bounce flip and a dir press in the same cycle cancel through the XOR.
  always_comb begin
    step = (state_q == ST_RUN) && tick;
    flip = 1'b0;
    q_nx = q_q;
    if (cnt_up_q) begin
      if (q_q == 8'hFF) begin
        q_nx = mode_bounce ? 8'hFE : 8'h00;
        flip = mode_bounce;
      end else begin
        q_nx = q_q + 8'd1;
      end
    end else begin
      if (q_q == 8'h00) begin
        q_nx = mode_bounce ? 8'h01 : 8'hFF;
        flip = mode_bounce;
      end else begin
        q_nx = q_q - 8'd1;
      end
    end
    q_d      = step ? q_nx : q_q;
    cnt_en_d = step;
    cnt_up_d = cnt_up_q ^ press[B_DIR] ^ (step & flip);
    sel_d    = sel_q + {1'b0, press[B_RATE]};
    state_d  = state_q;
    if (press[B_RUN]) state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_STOP;
      q_q      <= 8'h00;
      cnt_up_q <= 1'b1;
      cnt_en_q <= 1'b0;
      sel_q    <= SEL_RESET;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      cnt_up_q <= cnt_up_d;
      cnt_en_q <= cnt_en_d;
      sel_q    <= sel_d;
    end
  end

  assign sel     = sel_q;
  assign q       = q_q;
  assign cnt_up  = cnt_up_q;
  assign cnt_en  = cnt_en_q;
  assign running = (state_q == ST_RUN);
endmodule

// File: tb/tb_updown_ctrl.sv
`timescale 1ns/1ps
// Directed plus randomized bench for updown_ctrl, with DB_CYCLES=4.
module tb_updown_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_run = 1'b0, btn_dir = 1'b0, btn_rate = 1'b0;
  logic       mode_bounce = 1'b0, tick_in = 1'b0;
  logic [1:0] sel;
  logic [7:0] q;
  logic       cnt_up, cnt_en, running;

  int vectors = 0;
  int miscompares = 0;
  int en_cnt = 0;

  updown_ctrl #(.DB_CYCLES(4), .SEL_RESET(2'd2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_dir(btn_dir),
    .btn_rate(btn_rate), .mode_bounce(mode_bounce), .tick_in(tick_in),
    .sel(sel), .q(q), .cnt_up(cnt_up), .cnt_en(cnt_en), .running(running)
  );

  always #5 clk = ~clk;

  // Count every cycle with the step strobe high.
  always @(posedge clk) if (cnt_en) en_cnt <= en_cnt + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_run = v;
      1: btn_dir = v;
      default: btn_rate = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1); cyc(10);
    set_btn(b, 1'b0); cyc(10);
  endtask

  task automatic tick();
    tick_in = 1'b1; cyc(2);
    tick_in = 1'b0; cyc(3);
  endtask

  // 20 toggles at one clk each give 10 rising edges, the sel=0 rate.
  task automatic fast_burst();
    for (int i = 0; i < 20; i++) begin
      tick_in = ~tick_in; cyc(1);
    end
    tick_in = 1'b0; cyc(4);
  endtask

  // The press pulse for button b and the tick pulse reach the FSM on the same edge.
  task automatic coincide(input int b);
    set_btn(b, 1'b1); cyc(4);
    tick_in = 1'b1; cyc(2);
    tick_in = 1'b0; cyc(6);
    set_btn(b, 1'b0); cyc(10);
  endtask

  // Reference step: move one position, then fold back or wrap into 0..255.
  int mq;
  bit mup;
  task automatic model_step(input bit mb);
    mq = mup ? mq + 1 : mq - 1;
    if (mq > 255) begin
      if (mb) begin mq = 254; mup = 1'b0; end else mq = 0;
    end else if (mq < 0) begin
      if (mb) begin mq = 1; mup = 1'b1; end else mq = 255;
    end
  endtask

  initial begin
    int e0;
    int burst;
    cyc(5);
    chk("rst_q", q, 0);
    chk("rst_up", cnt_up, 1);
    chk("rst_running", running, 0);
    chk("rst_sel", sel, 2);
    chk("rst_en", cnt_en, 0);
    rst_n = 1'b1;
    cyc(2);

    // Rate presses from reset: 2 -> 3 -> 0 -> 1.
    press(2); chk("sel_a", sel, 3);
    press(2); chk("sel_b", sel, 0);
    press(2); chk("sel_c", sel, 1);

    // Start and take three steps.
    press(0);
    chk("start_running", running, 1);
    for (int i = 1; i <= 3; i++) begin
      e0 = en_cnt;
      tick();
      chk("start_q", q, i);
      chk("start_en", en_cnt - e0, 1);
    end

    // Chatter must not be accepted. A held level must be accepted exactly once.
    for (int i = 0; i < 10; i++) begin
      btn_dir = 1'b1; cyc(2);
      btn_dir = 1'b0; cyc(2);
    end
    chk("chatter_up", cnt_up, 1);
    btn_dir = 1'b1; cyc(10);
    btn_dir = 1'b0; cyc(10);
    chk("db_up", cnt_up, 0);

    // Wrap mode: count down 3 -> 0, then wrap both ways.
    mode_bounce = 1'b0;
    repeat (3) tick();
    chk("down_q0", q, 0);
    tick();
    chk("wrap_dn_q", q, 255);
    chk("wrap_dn_up", cnt_up, 0);
    press(1);
    tick();
    chk("wrap_up_q", q, 0);
    chk("wrap_up_up", cnt_up, 1);
    press(1);
    tick();
    chk("wrap_dn2_q", q, 255);

    // Bounce mode at 255 while heading up.
    press(1);
    mode_bounce = 1'b1;
    tick();
    chk("bnc_hi_q", q, 254);
    chk("bnc_hi_up", cnt_up, 0);
    tick();
    chk("bnc_hi_q2", q, 253);
    e0 = en_cnt;
    repeat (253) tick();
    chk("bnc_to0_q", q, 0);
    chk("bnc_to0_en", en_cnt - e0, 253);
    // Limit tick with a dir press on the same edge: the flip and the press cancel.
    coincide(1);
    chk("bnc_lo_q", q, 1);
    chk("bnc_lo_up", cnt_up, 0);

    // Randomized walk against the reference model.
    mq = 1; mup = 1'b0;
    for (int it = 0; it < 40; it++) begin
      mode_bounce = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        press(1);
        mup = ~mup;
      end
      burst = $urandom_range(1, 6);
      e0 = en_cnt;
      for (int k = 0; k < burst; k++) begin
        tick();
        model_step(mode_bounce);
      end
      chk("rnd_q", q, mq);
      chk("rnd_up", cnt_up, int'(mup));
      chk("rnd_en", en_cnt - e0, burst);
    end

    // A run press and a tick on the same edge in RUN: one step, then STOP.
    e0 = en_cnt;
    coincide(0);
    model_step(mode_bounce);
    chk("stop_q", q, mq);
    chk("stop_running", running, 0);
    chk("stop_en", en_cnt - e0, 1);
    repeat (3) tick();
    chk("stopped_q", q, mq);
    chk("stopped_en", en_cnt - e0, 1);

    // Reset, reach 77 at sel=0 using fast ticks, then assert reset mid-cycle.
    rst_n = 1'b0; cyc(2);
    chk("rst2_sel", sel, 2);
    rst_n = 1'b1; cyc(2);
    mode_bounce = 1'b0;
    press(2); press(2);
    chk("sel0", sel, 0);
    press(0);
    e0 = en_cnt;
    repeat (7) fast_burst();
    chk("fast_q", q, 70);
    chk("fast_en", en_cnt - e0, 70);
    repeat (7) tick();
    chk("q77", q, 77);
    press(1);
    chk("pre_rst_up", cnt_up, 0);
    chk("pre_rst_running", running, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_q", q, 0);
    chk("async_up", cnt_up, 1);
    chk("async_running", running, 0);
    chk("async_sel", sel, 2);
    chk("async_en", cnt_en, 0);
    cyc(2);
    rst_n = 1'b1;
    e0 = en_cnt;
    tick();
    chk("post_rst_q", q, 0);
    chk("post_rst_en", en_cnt - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
